// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch PC stage.
//   PC_W_DEFAULT / DEPTH_DEFAULT : default PC width and return-stack depth
//   PC_SEQ / PC_JMP / PC_RET / PC_RSV : pc_src encodings from the controller
//   OP_BRANCH : instruction[18:16] value of a conditional branch
package fetch_pc_unit_pkg;

  localparam int unsigned PC_W_DEFAULT  = 12;
  localparam int unsigned DEPTH_DEFAULT = 8;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_JMP = 2'b01;
  localparam logic [1:0] PC_RET = 2'b10;
  localparam logic [1:0] PC_RSV = 2'b11;

  localparam logic [2:0] OP_BRANCH = 3'b101;

  function automatic logic is_branch(input logic [2:0] opcode);
    return opcode == OP_BRANCH;
  endfunction

endpackage

// File: rtl/fetch_pc_unit_return_stack.sv
// Hardware return-address LIFO for jsb/ret.
//   clk, rst      : clock, synchronous active-high reset (clears sp and flags, not memory)
//   en            : update enable; low freezes sp, contents and flags
//   push, pop     : push wdata / pop top; both together replace the top entry
//   ret_req       : a return is being taken this cycle (flags underflow when empty)
//   wdata         : return address to store
//   top           : combinational read of the newest entry, mem[sp-1]
//   sp            : occupancy 0..DEPTH
//   full, empty   : decoded from registered sp
//   overflow      : sticky, push attempted while full
//   underflow     : sticky, pop or return attempted while empty
module return_stack #(
  parameter int unsigned W     = 12,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     ret_req,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             top,
  output logic [$clog2(DEPTH):0]   sp,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] IdxOne = 1;
  localparam logic [AW:0]   SpOne  = 1;
  localparam logic [AW:0]   SpMax  = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW:0]   sp_q, sp_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          we;
  logic [AW-1:0] waddr;
  logic [AW-1:0] top_idx;

  assign full    = (sp_q == SpMax);
  assign empty   = (sp_q == '0);
  // When sp == DEPTH the low bits are zero, so this wraps to DEPTH-1 as intended.
  assign top_idx = sp_q[AW-1:0] - IdxOne;
  assign top     = mem_q[top_idx];

  always_comb begin
    sp_d        = sp_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    we          = 1'b0;
    waddr       = sp_q[AW-1:0];
    if (en) begin
      if (push && pop && !empty) begin
        // Replace: top is read before the write lands, so a same-cycle return still
        // sees the old entry.
        we    = 1'b1;
        waddr = top_idx;
      end else if (push) begin
        if (full) begin
          overflow_d = 1'b1;
        end else begin
          we   = 1'b1;
          sp_d = sp_q + SpOne;
        end
      end else if (pop) begin
        if (empty) begin
          underflow_d = 1'b1;
        end else begin
          sp_d = sp_q - SpOne;
        end
      end
      if (ret_req && empty) begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q        <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Contents are deliberately not reset; sp alone defines what is valid.
  always_ff @(posedge clk) begin
    if (!rst && we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign sp        = sp_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter and next-PC selection upstream of the controller.
//   clk, rst     : clock, synchronous active-high reset
//   hold         : memory stall, freezes PC and stack
//   instruction  : current 19-bit instruction word at address pc
//   pc_src       : 00 sequential, 01 jump/taken branch, 10 return, 11 reserved
//   stack_push   : push pc+1 (jsb)
//   stack_pop    : pop return address (ret)
//   pc           : registered PC, instruction memory address
//   sp           : return-stack occupancy 0..DEPTH
//   stack_full, stack_empty : occupancy decodes
//   overflow, underflow     : sticky stack error flags, cleared by rst only
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int unsigned PC_W  = PC_W_DEFAULT,
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hold,
  input  logic [18:0]            instruction,
  input  logic [1:0]             pc_src,
  input  logic                   stack_push,
  input  logic                   stack_pop,
  output logic [PC_W-1:0]        pc,
  output logic [$clog2(DEPTH):0] sp,
  output logic                   stack_full,
  output logic                   stack_empty,
  output logic                   overflow,
  output logic                   underflow
);

  localparam logic [PC_W-1:0] PcOne = 1;

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_plus1;
  logic [PC_W-1:0] branch_off;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] stack_top;
  logic            ret_req;

  assign pc_plus1   = pc_q + PcOne;
  assign branch_off = {{(PC_W - 8){instruction[7]}}, instruction[7:0]};
  assign target     = is_branch(instruction[18:16]) ? (pc_plus1 + branch_off)
                                                    : PC_W'(instruction[11:0]);
  assign ret_req    = (pc_src == PC_RET);

  return_stack #(
    .W     (PC_W),
    .DEPTH (DEPTH)
  ) u_return_stack (
    .clk       (clk),
    .rst       (rst),
    .en        (!hold),
    .push      (stack_push),
    .pop       (stack_pop),
    .ret_req   (ret_req),
    .wdata     (pc_plus1),
    .top       (stack_top),
    .sp        (sp),
    .full      (stack_full),
    .empty     (stack_empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always_comb begin
    pc_d = pc_q;
    if (!hold) begin
      unique case (pc_src)
        PC_JMP:  pc_d = target;
        // An empty-stack return falls through to sequential; the stack flags it.
        PC_RET:  pc_d = stack_empty ? pc_plus1 : stack_top;
        default: pc_d = pc_plus1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic [18:0] instruction;
  logic [1:0]  pc_src;
  logic        stack_push;
  logic        stack_pop;
  logic [11:0] pc;
  logic [3:0]  sp;
  logic        stack_full;
  logic        stack_empty;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_pc;
  int m_stk[$];
  bit m_ov;
  bit m_un;

  always #5 clk = ~clk;

  fetch_pc_unit #(
    .PC_W  (12),
    .DEPTH (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .hold        (hold),
    .instruction (instruction),
    .pc_src      (pc_src),
    .stack_push  (stack_push),
    .stack_pop   (stack_pop),
    .pc          (pc),
    .sp          (sp),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  function automatic logic [18:0] jmp(input logic [11:0] a);
    return {3'b111, 4'b0000, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic h, input logic [18:0] ins,
                       input logic [1:0] src, input logic pu, input logic po);
    int pp, tgt, npc, off;
    bit emp;
    if (r) begin
      m_pc = 0;
      m_stk.delete();
      m_ov = 0;
      m_un = 0;
      return;
    end
    if (h) return;
    pp  = (m_pc + 1) % 4096;
    off = int'($signed(ins[7:0]));
    tgt = (ins[18:16] == 3'b101) ? ((pp + off) & 'hFFF) : int'(ins[11:0]);
    emp = (m_stk.size() == 0);
    npc = pp;
    if (src == 2'b01) npc = tgt;
    else if (src == 2'b10) begin
      if (emp) m_un = 1;
      else npc = m_stk[m_stk.size() - 1];
    end
    if (pu && po && !emp) m_stk[m_stk.size() - 1] = pp;
    else if (pu) begin
      if (m_stk.size() == 8) m_ov = 1;
      else m_stk.push_back(pp);
    end else if (po) begin
      if (emp) m_un = 1;
      else void'(m_stk.pop_back());
    end
    m_pc = npc;
  endtask

  task automatic step(input logic r, input logic h, input logic [18:0] ins,
                      input logic [1:0] src, input logic pu, input logic po);
    rst         = r;
    hold        = h;
    instruction = ins;
    pc_src      = src;
    stack_push  = pu;
    stack_pop   = po;
    model(r, h, ins, src, pu, po);
    @(posedge clk);
    #1;
    check("pc", 32'(pc), 32'(m_pc));
    check("sp", 32'(sp), 32'(m_stk.size()));
    check("full", 32'(stack_full), 32'(m_stk.size() == 8));
    check("empty", 32'(stack_empty), 32'(m_stk.size() == 0));
    check("overflow", 32'(overflow), 32'(m_ov));
    check("underflow", 32'(underflow), 32'(m_un));
  endtask

  initial begin
    int ret_addr[8];
    int from;
    logic [18:0] ins;

    rst = 1'b1; hold = 1'b0; instruction = '0; pc_src = 2'b00;
    stack_push = 1'b0; stack_pop = 1'b0;
    m_pc = 0; m_ov = 0; m_un = 0;

    // Reset state
    step(1, 0, '0, 2'b00, 0, 0);
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_empty", 32'(stack_empty), 32'h1);

    // Sequential fetch
    for (int i = 1; i <= 5; i++) begin
      step(0, 0, '0, 2'b00, 0, 0);
      check("seq_pc", 32'(pc), 32'(i));
      check("seq_empty", 32'(stack_empty), 32'h1);
    end

    // Backward branch and PC wrap
    step(0, 0, jmp(12'h010), 2'b01, 0, 0);
    step(0, 0, {3'b101, 8'h00, 8'hFC}, 2'b01, 0, 0);
    check("branch_back", 32'(pc), 32'h00D);
    step(0, 0, jmp(12'hFFF), 2'b01, 0, 0);
    step(0, 0, '0, 2'b00, 0, 0);
    check("pc_wrap", 32'(pc), 32'h000);

    // Single call/return
    step(0, 0, jmp(12'h020), 2'b01, 0, 0);
    step(0, 0, jmp(12'h300), 2'b01, 1, 0);
    check("jsb_pc", 32'(pc), 32'h300);
    check("jsb_sp", 32'(sp), 32'h1);
    step(0, 0, jmp(12'h305), 2'b01, 0, 0);
    step(0, 0, '0, 2'b10, 0, 1);
    check("ret_pc", 32'(pc), 32'h021);
    check("ret_sp", 32'(sp), 32'h0);

    // Fill the stack, overflow, then unwind in LIFO order
    step(0, 0, jmp(12'h100), 2'b01, 0, 0);
    for (int i = 0; i < 8; i++) begin
      from = (i == 0) ? 'h100 : ('h200 + (i - 1) * 16);
      ret_addr[i] = from + 1;
      step(0, 0, jmp(12'('h200 + i * 16)), 2'b01, 1, 0);
    end
    check("full_after_8", 32'(stack_full), 32'h1);
    step(0, 0, jmp(12'h400), 2'b01, 1, 0);
    check("ovf_flag", 32'(overflow), 32'h1);
    check("ovf_sp", 32'(sp), 32'h8);
    check("ovf_pc", 32'(pc), 32'h400);
    for (int i = 7; i >= 0; i--) begin
      step(0, 0, '0, 2'b10, 0, 1);
      check("unwind_pc", 32'(pc), 32'(ret_addr[i]));
    end
    check("unwind_empty", 32'(stack_empty), 32'h1);

    // Return on empty stack
    step(0, 0, jmp(12'h040), 2'b01, 0, 0);
    step(0, 0, '0, 2'b10, 0, 1);
    check("unf_pc", 32'(pc), 32'h041);
    check("unf_flag", 32'(underflow), 32'h1);
    for (int i = 0; i < 3; i++) step(0, 0, '0, 2'b00, 0, 0);
    check("unf_sticky", 32'(underflow), 32'h1);

    // Hold during jsb, then reset mid-call
    step(1, 0, '0, 2'b00, 0, 0);
    step(0, 0, jmp(12'h500), 2'b01, 1, 0);
    step(0, 0, jmp(12'h510), 2'b01, 1, 0);
    step(0, 0, jmp(12'h520), 2'b01, 1, 0);
    step(0, 1, jmp(12'h600), 2'b01, 1, 0);
    check("hold_pc", 32'(pc), 32'h520);
    check("hold_sp", 32'(sp), 32'h3);
    step(1, 0, jmp(12'h600), 2'b01, 1, 0);
    check("rst_mid_pc", 32'(pc), 32'h0);
    check("rst_mid_sp", 32'(sp), 32'h0);
    check("rst_mid_ovf", 32'(overflow), 32'h0);
    check("rst_mid_unf", 32'(underflow), 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 500; n++) begin
      ins = 19'($urandom);
      if ($urandom_range(0, 1) == 0) ins[18:16] = 3'b101;
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 9) == 0),
           ins,
           2'($urandom_range(0, 3)),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Program-counter and return-address-stack stage that sits directly upstream of the MIPS controller. It holds the 12-bit PC that addresses instruction memory and computes the next PC from the controller's `pc_src`, `stack_push` and `stack_pop` outputs and the current 19-bit instruction word. It also owns the 8-entry hardware call stack used by `jsb`/`ret`. Overflow and underflow are flagged and never silently corrupt control flow.

## Interface
Parameters:
- `PC_W`, 12: PC and stack-entry width.
- `DEPTH`, 8: return-stack entries (power of two).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `hold`  in  1  freezes PC and stack for this cycle (memory stall).
- `instruction`  in  19  current instruction word, from instruction memory at address `pc`.
- `pc_src`  in  2  next-PC select: 00 sequential, 01 jump/taken branch, 10 return, 11 reserved.
- `stack_push`  in  1  push return address (`jsb`).
- `stack_pop`  in  1  pop return address (`ret`).
- `pc`  out  PC_W  current PC, registered; drives instruction memory address.
- `sp`  out  log2(DEPTH)+1  current stack occupancy, 0..DEPTH.
- `stack_full`  out  1  `sp == DEPTH`.
- `stack_empty`  out  1  `sp == 0`.
- `overflow`  out  1  sticky: a push was attempted while full.
- `underflow`  out  1  sticky: a pop was attempted while empty.

## Operation
- `pc_plus1 = pc + 1`, modulo 2^PC_W; 0xFFF wraps to 0x000.
- Branch vs jump target is selected by `instruction[18:16]`:
  - 101 (conditional branch): target = `pc_plus1 + sext(instruction[7:0])`, modulo 2^PC_W.
  - Otherwise (1110x jump/jsb): target = `instruction[11:0]`.
- Next PC:
  - `pc_src` 00: `pc_plus1`.
  - `pc_src` 01: target.
  - `pc_src` 10: top of stack. If the stack is empty, use `pc_plus1` and set `underflow`.
  - `pc_src` 11: `pc_plus1` (reserved; no other effect).
- Push only (`stack_push`=1, `stack_pop`=0):
  - Not full: `mem[sp] <= pc_plus1`, `sp <= sp+1`.
  - Full: no write, `sp` unchanged, set `overflow`.
- Pop only: if not empty, `sp <= sp-1`. The popped value is the one used by `pc_src`=10 in the same cycle.
- Push and pop together (not issued by the controller; behaviour is defined anyway):
  - Stack not empty: replace the top entry with `pc_plus1`; `sp` unchanged.
  - Stack empty: behaves as a plain push.
- `stack_pop` with `pc_src` other than 10 still pops; the popped value is discarded.
- `hold`=1: PC, `sp`, stack contents and flags are all unchanged, and push/pop are ignored.
- `overflow` and `underflow` are cleared only by `rst`.

## Timing
- Single-cycle next-PC logic. The new `pc` is visible one clock after the inputs are sampled.
- Stack read is combinational from `mem[sp-1]`. A push at edge N is readable by a pop at edge N+1.
- Reset values: `pc`=0, `sp`=0, `stack_full`=0, `stack_empty`=1, `overflow`=0, `underflow`=0. Stack memory is not cleared.
- `rst` takes priority over `hold` and over any push/pop in the same cycle. Reset mid-call-sequence discards all stacked return addresses.
- `stack_full`/`stack_empty` are decoded from registered `sp`, so they have no extra latency.

## Structure
- Shared package holds:
  - `PC_W` and `DEPTH` defaults.
  - `pc_src` encodings (`PC_SEQ`=00, `PC_JMP`=01, `PC_RET`=10).
  - Opcode constant `OP_BRANCH`=3'b101.
- One sub-module, `return_stack`: a LIFO with push/pop/replace, `sp`, full/empty and overflow/underflow.
- `fetch_pc_unit` contains the PC register, the target adder and the next-PC mux, and instantiates `return_stack`.

## Test plan
- Reset then 5 cycles with `pc_src`=00 → `pc` = 0,1,2,3,4,5; `stack_empty`=1.
- At `pc`=0x010, a branch with `instruction[18:16]`=101, `[7:0]`=0xFC, `pc_src`=01 → `pc`=0x00D. At `pc`=0xFFF with `pc_src`=00 → `pc`=0x000.
- At `pc`=0x020, a `jsb` to 0x300 (`pc_src`=01, push) → `pc`=0x300, `sp`=1. Then at 0x305 a `ret` (`pc_src`=10, pop) → `pc`=0x021, `sp`=0.
- 8 nested `jsb` → `stack_full`=1. A 9th `jsb` → `overflow`=1, `sp`=8, and the PC still jumps. Then 8 `ret` return to the recorded addresses in LIFO order.
- `ret` on empty stack at `pc`=0x040 → `pc`=0x041, `underflow`=1, sticky until `rst`.
- `hold`=1 during a `jsb` → `pc` and `sp` unchanged. `rst` asserted with `sp`=3 → next cycle `pc`=0, `sp`=0, flags 0.
